// File: rtl/freq_counter_if.sv
// Measurement bus of the QCM frequency counter: enable and oscillator input
// toward the counter, frequency word with its valid pulse and overflow flag back.
interface freq_counter_if #(
    parameter int F_WIDTH = 14
);
    logic               en;
    logic               sig_in;
    logic [F_WIDTH-1:0] f;
    logic               f_valid;
    logic               ovf;

    modport master (
        output en,
        output sig_in,
        input  f,
        input  f_valid,
        input  ovf
    );

    modport slave (
        input  en,
        input  sig_in,
        output f,
        output f_valid,
        output ovf
    );
endinterface

// File: rtl/freq_counter.sv
// QCM oscillator frequency counter: counts synchronized rising edges of sig_in
// over back-to-back gate windows of GATE_CYCLES clocks and publishes the
// saturating count as the frequency word f (kHz with 8 MHz clk and 1 ms gate).
module freq_counter #(
    parameter int F_WIDTH     = 14,
    parameter int GATE_CYCLES = 8000,
    parameter int GATE_W      = 13
) (
    input  logic          clk,
    input  logic          rst,
    freq_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_t;

    localparam logic [F_WIDTH-1:0] CNT_MAX   = {F_WIDTH{1'b1}};
    localparam logic [F_WIDTH-1:0] CNT_ONE   = F_WIDTH'(1);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0]  ARM_LAST  = GATE_W'(2);
    localparam logic [GATE_W-1:0]  GATE_ONE  = GATE_W'(1);

    state_t             state;
    state_t             state_next;
    logic               s1;
    logic               s2;
    logic               s3;
    logic               edge_seen;
    logic [GATE_W-1:0]  gate_cnt;
    logic [F_WIDTH-1:0] edge_cnt;
    logic [F_WIDTH-1:0] cnt_upd;
    logic               sat;
    logic               sat_upd;
    logic               arm_done;
    logic               gate_done;
    logic [F_WIDTH-1:0] f_word;
    logic               ovf_flag;
    logic               valid_pulse;

    // The synchronizer regs start at 0, so a sig_in already high at reset
    // release shows up as one rising edge.
    assign edge_seen = s2 & ~s3;
    assign arm_done  = (gate_cnt == ARM_LAST);
    assign gate_done = (gate_cnt == GATE_LAST);

    // Three-flop synchronizer for the asynchronous oscillator input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Saturating edge count including this cycle's edge; the count never wraps.
    always_comb begin
        cnt_upd = edge_cnt;
        sat_upd = sat;
        if (edge_seen) begin
            if (edge_cnt == CNT_MAX) begin
                sat_upd = 1'b1;
            end else begin
                cnt_upd = edge_cnt + CNT_ONE;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: ARM flushes stale synchronizer contents before counting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (!bus.en) begin
                    state_next = IDLE;
                end else if (arm_done) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (!bus.en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate and edge counters; a finished window restarts them in the same
    // cycle so consecutive windows have no dead time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    gate_cnt <= (bus.en && !arm_done) ? gate_cnt + GATE_ONE : '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                end
                COUNT: begin
                    if (!bus.en || gate_done) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_ONE;
                        edge_cnt <= cnt_upd;
                        sat      <= sat_upd;
                    end
                end
                default: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                end
            endcase
        end
    end

    // Publish the completed window; a window abandoned by en=0 leaves f/ovf untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_word      <= '0;
            ovf_flag    <= 1'b0;
            valid_pulse <= 1'b0;
        end else begin
            valid_pulse <= 1'b0;
            if (state == COUNT && bus.en && gate_done) begin
                f_word      <= cnt_upd;
                ovf_flag    <= sat_upd;
                valid_pulse <= 1'b1;
            end
        end
    end

    assign bus.f       = f_word;
    assign bus.ovf     = ovf_flag;
    assign bus.f_valid = valid_pulse;
endmodule

// File: tb/tb_freq_counter.sv
// Bench for freq_counter: a default-size instance (1 ms gate) for timing and
// enable/reset behaviour, and a small instance (8-bit word, 600-cycle gate)
// for saturation and randomized edge patterns against an edge-count model.
module tb_freq_counter;
    localparam int GA   = 8000;
    localparam int FWA  = 14;
    localparam int GB   = 600;
    localparam int FWB  = 8;
    localparam int MAXB = (1 << FWB) - 1;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   per_a = 8;
    int   ph_a  = 0;

    always #5 clk = ~clk;

    freq_counter_if #(.F_WIDTH(FWA)) bus_a ();
    freq_counter_if #(.F_WIDTH(FWB)) bus_b ();

    freq_counter #(.F_WIDTH(FWA), .GATE_CYCLES(GA), .GATE_W(13)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    freq_counter #(.F_WIDTH(FWB), .GATE_CYCLES(GB), .GATE_W(10)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Square-wave oscillator for instance A; period per_a clk cycles, 0 holds it low.
    initial begin
        bus_a.sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (per_a < 2) begin
                ph_a = 0;
                bus_a.sig_in = 1'b0;
            end else begin
                ph_a = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
                bus_a.sig_in = (ph_a < per_a / 2);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse_a(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus_a.f_valid && n < limit);
    endtask

    task automatic wait_pulse_b(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus_b.f_valid && n < limit);
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        repeat (20) tick();
        total++;
        if (bus_a.f !== '0 || bus_a.f_valid !== 1'b0 || bus_a.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_a: f=%0d f_valid=%b ovf=%b, expected 0/0/0",
                     bus_a.f, bus_a.f_valid, bus_a.ovf);
        end
        total++;
        if (bus_b.f !== '0 || bus_b.f_valid !== 1'b0 || bus_b.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_b: f=%0d f_valid=%b ovf=%b, expected 0/0/0",
                     bus_b.f, bus_b.f_valid, bus_b.ovf);
        end
        rst = 1'b0;
        pulses = 0;
        repeat (200) begin
            tick();
            if (bus_a.f_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || bus_a.f !== '0) begin
            bad++;
            $display("FAIL idle_after_reset: pulses=%0d f=%0d, expected 0 pulses f=0",
                     pulses, bus_a.f);
        end
    endtask

    task automatic test_default();
        int n;
        bus_a.en = 1'b1;
        wait_pulse_a(GA + 100, n);
        total++;
        if (n != GA + 4) begin
            bad++;
            $display("FAIL first_pulse_latency: got %0d cycles, expected %0d", n, GA + 4);
        end
        total++;
        if (bus_a.f !== FWA'(1000) || bus_a.ovf !== 1'b0) begin
            bad++;
            $display("FAIL first_window: f=%0d ovf=%b, expected 1000/0", bus_a.f, bus_a.ovf);
        end
        tick();
        total++;
        if (bus_a.f_valid !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width: f_valid=%b one cycle after pulse, expected 0", bus_a.f_valid);
        end
        wait_pulse_a(GA + 100, n);
        total++;
        if (n != GA - 1 || bus_a.f !== FWA'(1000)) begin
            bad++;
            $display("FAIL second_window: spacing=%0d f=%0d, expected %0d / 1000",
                     n + 1, bus_a.f, GA);
        end
    endtask

    task automatic test_mixed();
        int n;
        per_a = 16;
        repeat (4000) tick();
        per_a = 8;
        wait_pulse_a(GA + 100, n);
        total++;
        if (n != GA - 4000 || int'(bus_a.f) <= 500 || int'(bus_a.f) >= 1000) begin
            bad++;
            $display("FAIL mixed_window: wait=%0d f=%0d, expected %0d and 500<f<1000",
                     n, bus_a.f, GA - 4000);
        end
        wait_pulse_a(GA + 100, n);
        total++;
        if (n != GA || bus_a.f !== FWA'(1000) || bus_a.ovf !== 1'b0) begin
            bad++;
            $display("FAIL after_mixed: spacing=%0d f=%0d ovf=%b, expected %0d/1000/0",
                     n, bus_a.f, bus_a.ovf, GA);
        end
    endtask

    task automatic test_disable();
        int n;
        int pulses;
        repeat (4000) tick();
        bus_a.en = 1'b0;
        pulses = 0;
        repeat (GA + 200) begin
            tick();
            if (bus_a.f_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || bus_a.f !== FWA'(1000)) begin
            bad++;
            $display("FAIL disable_discard: pulses=%0d f=%0d, expected 0 pulses f=1000",
                     pulses, bus_a.f);
        end
        bus_a.en = 1'b1;
        wait_pulse_a(GA + 100, n);
        total++;
        if (n != GA + 4 || bus_a.f !== FWA'(1000)) begin
            bad++;
            $display("FAIL reenable: latency=%0d f=%0d, expected %0d / 1000", n, bus_a.f, GA + 4);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        per_a = 0;
        repeat (3000) tick();
        rst = 1'b1;
        #1;
        total++;
        if (bus_a.f !== '0 || bus_a.f_valid !== 1'b0 || bus_a.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_window: f=%0d f_valid=%b ovf=%b, expected 0/0/0",
                     bus_a.f, bus_a.f_valid, bus_a.ovf);
        end
        tick();
        tick();
        rst = 1'b0;
        wait_pulse_a(GA + 100, n);
        total++;
        if (n != GA + 4 || bus_a.f !== '0 || bus_a.ovf !== 1'b0) begin
            bad++;
            $display("FAIL zero_window_after_reset: latency=%0d f=%0d ovf=%b, expected %0d/0/0",
                     n, bus_a.f, bus_a.ovf, GA + 4);
        end
    endtask

    // Drives one full window on instance B (quiet margins at both ends) and
    // compares the published word with the number of rising edges driven.
    task automatic run_window_b(input int mode, input int dens, input string name);
        int   cnt;
        int   early;
        int   exp_f;
        logic exp_o;
        logic prev;
        logic v;
        cnt = 0;
        early = 0;
        prev = 1'b0;
        for (int k = 0; k < GB; k++) begin
            if (k < 10 || k >= GB - 20) v = 1'b0;
            else if (mode == 0) v = ((k - 10) % 2 == 0);
            else if (mode == 1) v = (((k - 10) % 8) < 4);
            else v = ($urandom_range(0, 99) < dens);
            if (v && !prev) cnt++;
            prev = v;
            bus_b.sig_in = v;
            tick();
            if (k < GB - 1 && bus_b.f_valid === 1'b1) early++;
        end
        exp_f = (cnt > MAXB) ? MAXB : cnt;
        exp_o = (cnt > MAXB);
        total++;
        if (early != 0 || bus_b.f_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timing: early_pulses=%0d f_valid=%b, expected 0 and 1",
                     name, early, bus_b.f_valid);
        end
        total++;
        if (bus_b.f !== FWB'(exp_f) || bus_b.ovf !== exp_o) begin
            bad++;
            $display("FAIL %s_value: f=%0d ovf=%b, expected %0d/%b (edges=%0d)",
                     name, bus_b.f, bus_b.ovf, exp_f, exp_o, cnt);
        end
    endtask

    task automatic test_saturation();
        int n;
        bus_b.sig_in = 1'b0;
        bus_b.en = 1'b1;
        wait_pulse_b(GB + 50, n);
        total++;
        if (n != GB + 4 || bus_b.f !== '0) begin
            bad++;
            $display("FAIL small_first_pulse: latency=%0d f=%0d, expected %0d / 0", n, bus_b.f, GB + 4);
        end
        run_window_b(0, 0, "saturate");
        run_window_b(1, 0, "slow_after_sat");
    endtask

    task automatic test_random();
        for (int w = 0; w < 6; w++) begin
            run_window_b(2, $urandom_range(10, 60), "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        bus_b.sig_in = 1'b0;
        test_reset();
        test_default();
        test_mixed();
        test_disable();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
